// File: rtl/apb_uart_pkg.sv
// Shared types and widths for the two-requester APB arbiter.
package apb_uart_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int CS_W   = 2;
endpackage

// File: rtl/apb_uart_arbiter_rr.sv
// Two-way round-robin grant: masked requests, pointer breaks ties (0 favours requester 0).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       ptr,
  output logic [1:0] grant
);
  logic [1:0] eff_s;

  // One-hot grant from the unmasked requests
  always_comb begin
    eff_s = req & ~mask;
    grant = 2'b00;
    case (eff_s)
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = eff_s;
    endcase
  end
endmodule

// File: rtl/apb_uart_arbiter.sv
// APB master shared by two requesters with round-robin arbitration.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_uart_arbiter
  import apb_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*CS_W-1:0]   req_cs,
  output logic [1:0]          req_done,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                req_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [CS_W-1:0]     pcs,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready
);
  state_t     state_r, state_nxt_s;
  logic [1:0] gnt_s;
  logic       gidx_s;
  logic       gnt_idx_r;
  logic       ptr_r;
  logic       take_s, complete_s, abort_s, timeout_hit_s;

  // A requester whose done pulse is visible this cycle is kept out of arbitration
  rr_arbiter2 u_rr (
    .req   (req_valid),
    .mask  (req_done),
    .ptr   (ptr_r),
    .grant (gnt_s)
  );

  assign gidx_s = gnt_s[1];

  // FSM state register
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next state and transition strobes
  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    complete_s  = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (|gnt_s) begin
          state_nxt_s = SETUP;
          take_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: state_nxt_s = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_nxt_s = IDLE;
          complete_s  = 1'b1;
        end else if (timeout_hit_s) begin
          state_nxt_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Registered APB outputs, grant latch, pointer and completion pulse
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= {ADDR_W{1'b0}};
      pwdata    <= {DATA_W{1'b0}};
      pcs       <= {CS_W{1'b0}};
      req_done  <= 2'b00;
      req_rdata <= {DATA_W{1'b0}};
      gnt_idx_r <= 1'b0;
      ptr_r     <= 1'b0;
    end else begin
      req_done <= 2'b00;
      if (take_s) begin
        psel      <= 1'b1;
        penable   <= 1'b0;
        gnt_idx_r <= gidx_s;
        ptr_r     <= gnt_s[0];
        pwrite    <= req_write[gidx_s];
        paddr     <= req_addr[{gidx_s, 1'b0} +: ADDR_W];
        pwdata    <= req_wdata[{gidx_s, 3'b000} +: DATA_W];
        pcs       <= req_cs[{gidx_s, 1'b0} +: CS_W];
      end else if (state_r == SETUP) begin
        penable <= 1'b1;
      end else if (complete_s || abort_s) begin
        psel     <= 1'b0;
        penable  <= 1'b0;
        req_done <= gnt_idx_r ? 2'b10 : 2'b01;
        if (abort_s)      req_rdata <= {DATA_W{1'b0}};
        else if (!pwrite) req_rdata <= prdata;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  assign timeout_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive not-ready ACCESS cycles
  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                          tmo_cnt_r <= {TMO_W{1'b0}};
    else if (state_r != ACCESS)          tmo_cnt_r <= {TMO_W{1'b0}};
    else if (!pready && !timeout_hit_s)  tmo_cnt_r <= tmo_cnt_r + 1'b1;
    else                                 tmo_cnt_r <= {TMO_W{1'b0}};
  end

  // Error flag pulses alongside the abort done
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) req_err <= 1'b0;
    else        req_err <= abort_s;
  end
`else
  assign timeout_hit_s = 1'b0;
  assign req_err       = 1'b0;
`endif
endmodule
